// File: rtl/afu_shell_pkg.sv
// Shared types and constants for the AFU stream shell.
package afu_shell_pkg;

    localparam int DEF_LINE_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } shell_state_e;

endpackage

// File: rtl/syn_read_fifo.sv
// Line FIFO with a registered read port: dout updates on the edge that accepts re.
module syn_read_fifo #(
    parameter int WIDTH      = 512,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      din,
    input  logic                  we,
    input  logic                  re,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q;
    logic [DEPTH_BITS-1:0] rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic [WIDTH-1:0]      dout_q;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    // Writes while full and reads while empty are silently dropped.
    assign wr_ok = we && !full;
    assign rd_ok = re && !empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    // Pointers, occupancy and the registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/afu_stream_shell.sv
// Job-controlled stream shell: input FIFO -> credit-gated issue -> external core -> output FIFO.
module afu_stream_shell
    import afu_shell_pkg::*;
#(
    parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
    parameter int IN_DEPTH_BITS  = 3,
    parameter int OUT_DEPTH_BITS = 3,
    parameter int AF_MARGIN      = 4,
    parameter int AE_THRESHOLD   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             ctx_length,
    input  logic                    mode_bypass,
    input  logic [LINE_WIDTH-1:0]   input_fifo_din,
    input  logic                    input_fifo_we,
    output logic                    input_fifo_full,
    output logic                    input_fifo_almost_full,
    output logic [IN_DEPTH_BITS:0]  input_fifo_count,
    output logic [LINE_WIDTH-1:0]   output_fifo_dout,
    input  logic                    output_fifo_re,
    output logic                    output_fifo_empty,
    output logic                    output_fifo_almost_empty,
    output logic                    core_in_valid,
    output logic [LINE_WIDTH-1:0]   core_in_data,
    input  logic                    core_out_valid,
    input  logic [LINE_WIDTH-1:0]   core_out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_unexpected,
    output logic [31:0]             issued_count,
    output logic [31:0]             retired_count
);

    localparam logic [OUT_DEPTH_BITS:0] POOL_CNT = {1'b1, {OUT_DEPTH_BITS{1'b0}}};

    shell_state_e              state_q;
    logic [31:0]               len_q;
    logic                      bypass_q;
    logic [31:0]               issued_q;
    logic [31:0]               retired_q;
    logic [OUT_DEPTH_BITS:0]   inflight_q;
    logic                      pop_q;
    logic                      err_q;

    logic [LINE_WIDTH-1:0]     in_dout;
    logic                      in_empty;
    logic [OUT_DEPTH_BITS:0]   out_count;
    logic                      out_full;
    logic [OUT_DEPTH_BITS:0]   credit;
    logic                      pop;
    logic                      core_ret;
    logic                      core_err;
    logic                      retire;
    logic                      out_we;
    logic [LINE_WIDTH-1:0]     out_din;
    logic                      start_ok;

    syn_read_fifo #(.WIDTH(LINE_WIDTH), .DEPTH_BITS(IN_DEPTH_BITS)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (input_fifo_din),
        .we    (input_fifo_we),
        .re    (pop),
        .dout  (in_dout),
        .full  (input_fifo_full),
        .empty (in_empty),
        .count (input_fifo_count)
    );

    syn_read_fifo #(.WIDTH(LINE_WIDTH), .DEPTH_BITS(OUT_DEPTH_BITS)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (out_din),
        .we    (out_we),
        .re    (output_fifo_re),
        .dout  (output_fifo_dout),
        .full  (out_full),
        .empty (output_fifo_empty),
        .count (out_count)
    );

    // Credits reserve an output slot for every line already in the core, so the core cannot overflow it.
    assign credit   = POOL_CNT - out_count - inflight_q;
    assign pop      = (state_q == RUN) && !in_empty && (issued_q < len_q) && (credit != '0);
    assign core_ret = core_out_valid && !bypass_q && (inflight_q != '0);
    assign core_err = core_out_valid && !bypass_q && (inflight_q == '0);
    assign retire   = bypass_q ? pop_q : core_ret;
    assign out_we   = retire || (core_err && !out_full);
    assign out_din  = bypass_q ? in_dout : core_out_data;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    assign core_in_valid            = pop_q && !bypass_q;
    assign core_in_data             = in_dout;
    assign busy                     = (state_q == RUN) || (state_q == DRAIN);
    assign done                     = (state_q == DONE);
    assign err_unexpected           = err_q;
    assign issued_count             = issued_q;
    assign retired_count            = retired_q;
    assign input_fifo_almost_full   = (int'(input_fifo_count) >= (2 ** IN_DEPTH_BITS - AF_MARGIN));
    assign output_fifo_almost_empty = (int'(out_count) <= AE_THRESHOLD);

    // Job FSM plus the per-job issue/retire counters, cleared when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            bypass_q  <= 1'b0;
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        len_q    <= ctx_length;
                        bypass_q <= mode_bypass;
                        state_q  <= (ctx_length == '0) ? DONE : RUN;
                    end
                end
                RUN:     if (issued_q == len_q)  state_q <= DRAIN;
                DRAIN:   if (retired_q == len_q) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
            if (start_ok) begin
                issued_q  <= '0;
                retired_q <= '0;
            end else begin
                if (pop)    issued_q  <= issued_q + 32'd1;
                if (retire) retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Inflight tracking, the issue-delay flag, and the sticky unexpected-result error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= '0;
            pop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pop_q <= pop;
            if (core_err) err_q <= 1'b1;
            case ({pop, retire})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Output occupancy plus lines in the core must never exceed the credit pool.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (({1'b0, out_count} + {1'b0, inflight_q}) <= {1'b0, POOL_CNT})
                else $error("credit pool exceeded");
        end
    end

endmodule

// File: tb/tb_afu_stream_shell.sv
// Directed bench for afu_stream_shell with a 3-stage inverting core model.
module tb_afu_stream_shell;

    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   ctx_length = '0;
    logic          mode_bypass = 1'b0;
    logic [LW-1:0] input_fifo_din = '0;
    logic          input_fifo_we = 1'b0;
    logic          input_fifo_full;
    logic          input_fifo_almost_full;
    logic [3:0]    input_fifo_count;
    logic [LW-1:0] output_fifo_dout;
    logic          output_fifo_re = 1'b0;
    logic          output_fifo_empty;
    logic          output_fifo_almost_empty;
    logic          core_in_valid;
    logic [LW-1:0] core_in_data;
    logic          core_out_valid;
    logic [LW-1:0] core_out_data;
    logic          busy;
    logic          done;
    logic          err_unexpected;
    logic [31:0]   issued_count;
    logic [31:0]   retired_count;

    logic          core_en = 1'b1;
    logic          inj_v = 1'b0;
    logic [2:0]    pv = '0;
    logic [LW-1:0] pd [3];
    int            busy_cyc = 0;
    int            ci_cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    afu_stream_shell dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .ctx_length               (ctx_length),
        .mode_bypass              (mode_bypass),
        .input_fifo_din           (input_fifo_din),
        .input_fifo_we            (input_fifo_we),
        .input_fifo_full          (input_fifo_full),
        .input_fifo_almost_full   (input_fifo_almost_full),
        .input_fifo_count         (input_fifo_count),
        .output_fifo_dout         (output_fifo_dout),
        .output_fifo_re           (output_fifo_re),
        .output_fifo_empty        (output_fifo_empty),
        .output_fifo_almost_empty (output_fifo_almost_empty),
        .core_in_valid            (core_in_valid),
        .core_in_data             (core_in_data),
        .core_out_valid           (core_out_valid),
        .core_out_data            (core_out_data),
        .busy                     (busy),
        .done                     (done),
        .err_unexpected           (err_unexpected),
        .issued_count             (issued_count),
        .retired_count            (retired_count)
    );

    always #5 clk = ~clk;

    // Core model: three register stages, result is the bitwise inverse of the input line.
    always @(posedge clk) begin
        pv    <= {pv[1:0], core_in_valid & core_en};
        pd[0] <= ~core_in_data;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end
    assign core_out_valid = pv[2] | inj_v;
    assign core_out_data  = pd[2];

    // Free-running activity counters for "never asserted" checks.
    always @(posedge clk) begin
        if (busy)          busy_cyc <= busy_cyc + 1;
        if (core_in_valid) ci_cyc   <= ci_cyc + 1;
    end

    function automatic logic [LW-1:0] mkline(input int tag);
        logic [31:0] w;
        w = 32'hA500_0000 | tag;
        return {16{w}};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        input_fifo_we = 1'b0;
        output_fifo_re = 1'b0;
        inj_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [LW-1:0] d);
        int t = 0;
        while (input_fifo_full && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            vectors++; miscompares++;
            $display("FAIL wr_timeout input FIFO stayed full");
        end
        input_fifo_din = d;
        input_fifo_we = 1'b1;
        @(negedge clk);
        input_fifo_we = 1'b0;
    endtask

    task automatic host_read(output logic [LW-1:0] d);
        int t = 0;
        while (output_fifo_empty && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            vectors++; miscompares++;
            $display("FAIL rd_timeout output FIFO stayed empty");
        end
        output_fifo_re = 1'b1;
        @(negedge clk);
        output_fifo_re = 1'b0;
        d = output_fifo_dout;
    endtask

    task automatic start_job(input logic [31:0] len, input logic byp);
        ctx_length = len;
        mode_bypass = byp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (!done && t < bound) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({busy, done, err_unexpected, core_in_valid, input_fifo_full} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000", {busy, done, err_unexpected, core_in_valid, input_fifo_full});
        end
        vectors++;
        if (issued_count !== 32'd0 || retired_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", issued_count, retired_count);
        end
        vectors++;
        if (input_fifo_count !== 4'd0 || output_fifo_empty !== 1'b1 || output_fifo_almost_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_fifos got cnt=%0d empty=%b ae=%b want 0/1/1", input_fifo_count, output_fifo_empty, output_fifo_almost_empty);
        end
        vectors++;
        if (output_fifo_dout !== '0) begin
            miscompares++;
            $display("FAIL reset_dout got %h want 0", output_fifo_dout[31:0]);
        end
    endtask

    task automatic test_bypass();
        logic [LW-1:0] d;
        int ci0;
        ci0 = ci_cyc;
        for (int i = 0; i < 4; i++) host_write(mkline(i + 1));
        start_job(32'd4, 1'b1);
        wait_done(100);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_done got done=%b busy=%b want 1/0", done, busy);
        end
        vectors++;
        if (retired_count !== 32'd4 || issued_count !== 32'd4) begin
            miscompares++;
            $display("FAIL byp_counts got %0d/%0d want 4/4", issued_count, retired_count);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(d);
            vectors++;
            if (d !== mkline(i + 1)) begin
                miscompares++;
                $display("FAIL byp_data[%0d] got %h want %h", i, d[31:0], mkline(i + 1) & 32'hFFFF_FFFF);
            end
        end
        vectors++;
        if (ci_cyc != ci0) begin
            miscompares++;
            $display("FAIL byp_core_in got %0d cycles want 0", ci_cyc - ci0);
        end
        vectors++;
        if (output_fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL byp_empty got %b want 1", output_fifo_empty);
        end
    endtask

    task automatic test_backpressure();
        start_job(32'd20, 1'b0);
        fork
            begin
                for (int i = 0; i < 20; i++) host_write(mkline(100 + i));
            end
            begin
                logic [LW-1:0] d;
                repeat (80) @(negedge clk);
                vectors++;
                if (issued_count !== 32'd8 || retired_count !== 32'd8) begin
                    miscompares++;
                    $display("FAIL bp_stall got %0d/%0d want 8/8", issued_count, retired_count);
                end
                vectors++;
                if (input_fifo_full !== 1'b1 || input_fifo_almost_full !== 1'b1 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_flags got full=%b af=%b busy=%b want 1/1/1", input_fifo_full, input_fifo_almost_full, busy);
                end
                vectors++;
                if (output_fifo_empty !== 1'b0 || output_fifo_almost_empty !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_out got empty=%b ae=%b want 0/0", output_fifo_empty, output_fifo_almost_empty);
                end
                for (int j = 0; j < 20; j++) begin
                    host_read(d);
                    vectors++;
                    if (d !== ~mkline(100 + j)) begin
                        miscompares++;
                        $display("FAIL bp_data[%0d] got %h want %h", j, d[31:0], ~mkline(100 + j) & 32'hFFFF_FFFF);
                    end
                end
            end
        join
        wait_done(100);
        vectors++;
        if (done !== 1'b1 || retired_count !== 32'd20) begin
            miscompares++;
            $display("FAIL bp_done got done=%b retired=%0d want 1/20", done, retired_count);
        end
    endtask

    task automatic test_zero_len();
        int b0;
        apply_reset();
        host_write(mkline(50));
        host_write(mkline(51));
        b0 = busy_cyc;
        start_job(32'd0, 1'b0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL zl_done got %b want 1", done);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (busy_cyc != b0) begin
            miscompares++;
            $display("FAIL zl_busy got %0d busy cycles want 0", busy_cyc - b0);
        end
        vectors++;
        if (input_fifo_count !== 4'd2 || issued_count !== 32'd0) begin
            miscompares++;
            $display("FAIL zl_nopop got cnt=%0d issued=%0d want 2/0", input_fifo_count, issued_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start_job(32'd12, 1'b0);
        fork
            begin
                for (int i = 0; i < 12; i++) host_write(mkline(200 + i));
            end
            begin
                logic [LW-1:0] d;
                for (int j = 0; j < 12; j++) begin
                    host_read(d);
                    vectors++;
                    if (d !== ~mkline(200 + j)) begin
                        miscompares++;
                        $display("FAIL b2b_data[%0d] got %h want %h", j, d[31:0], ~mkline(200 + j) & 32'hFFFF_FFFF);
                    end
                end
            end
            begin
                int diff;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    diff = int'(issued_count) - int'(retired_count);
                    vectors++;
                    if (diff < 0 || diff > 8) begin
                        miscompares++;
                        $display("FAIL b2b_inflight got %0d want 0..8", diff);
                    end
                end
            end
        join
        wait_done(100);
        vectors++;
        if (done !== 1'b1 || retired_count !== 32'd12 || issued_count !== 32'd12) begin
            miscompares++;
            $display("FAIL b2b_done got done=%b %0d/%0d want 1 12/12", done, issued_count, retired_count);
        end
    endtask

    task automatic test_unexpected();
        apply_reset();
        inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        vectors++;
        if (err_unexpected !== 1'b1 || retired_count !== 32'd0) begin
            miscompares++;
            $display("FAIL ue_set got err=%b retired=%0d want 1/0", err_unexpected, retired_count);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (err_unexpected !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ue_sticky got err=%b busy=%b want 1/0", err_unexpected, busy);
        end
        apply_reset();
        vectors++;
        if (err_unexpected !== 1'b0) begin
            miscompares++;
            $display("FAIL ue_clear got %b want 0", err_unexpected);
        end
    endtask

    task automatic test_reset_drain();
        logic [LW-1:0] d;
        core_en = 1'b0;
        for (int i = 0; i < 3; i++) host_write(mkline(300 + i));
        start_job(32'd3, 1'b0);
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || issued_count !== 32'd3 || retired_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rd_drain got busy=%b %0d/%0d want 1 3/0", busy, issued_count, retired_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, err_unexpected} !== 3'b000 || issued_count !== 32'd0 || retired_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rd_idle got flags=%b %0d/%0d want 000 0/0", {busy, done, err_unexpected}, issued_count, retired_count);
        end
        vectors++;
        if (input_fifo_count !== 4'd0 || output_fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_fifos got cnt=%0d empty=%b want 0/1", input_fifo_count, output_fifo_empty);
        end
        core_en = 1'b1;
        repeat (4) @(negedge clk);
        host_write(mkline(400));
        host_write(mkline(401));
        start_job(32'd2, 1'b0);
        wait_done(100);
        vectors++;
        if (done !== 1'b1 || retired_count !== 32'd2) begin
            miscompares++;
            $display("FAIL rd_newjob got done=%b retired=%0d want 1/2", done, retired_count);
        end
        for (int i = 0; i < 2; i++) begin
            host_read(d);
            vectors++;
            if (d !== ~mkline(400 + i)) begin
                miscompares++;
                $display("FAIL rd_data[%0d] got %h want %h", i, d[31:0], ~mkline(400 + i) & 32'hFFFF_FFFF);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_unexpected();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
